imem_pipe: RTL and testbench

- Parametrised, pipelined instruction memory. It is the successor to the combinational fetch array.
- A fetch unit issues PC requests over a valid/ready handshake. The block returns instruction words in order, after a configurable read latency.
- A response queue absorbs backpressure. A flush input discards in-flight fetches on redirect.
- A write port loads the program. Misaligned or out-of-range PCs return a tagged error response.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_rsp_fifo.sv | 66 ++++++
 rtl/imem_pipe.sv | 145 ++++++++++++++
 tb/tb_imem_pipe.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, response bundle and PC legality check
// for the pipelined instruction memory (imem_pipe).
package imem_pkg;

    localparam int unsigned IMEM_XLEN = 32;
    localparam logic [31:0] IMEM_NOP  = 32'h0000_0013;

    // Default-width response bundle; the top re-declares it at XLEN.
    typedef struct packed {
        logic [IMEM_XLEN-1:0] addr;
        logic [IMEM_XLEN-1:0] instr;
        logic                 err;
    } imem_rsp_t;

    // A PC is illegal when it is not word aligned or points past the
    // last word of a depth-word array.
    function automatic logic imem_pc_err(
        input logic [63:0] pc,
        input int unsigned depth
    );
        return (pc[1:0] != 2'b00) || (pc >= (64'(depth) << 2));
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: synchronous first-word-fall-through response queue.
// Ports: clk_i/rst_i/flush_i, push_i+data_i, pop_i, data_o (head),
// empty_o/full_o. Push when full and pop when empty are ignored.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = imem_rsp_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/imem_pipe.sv
// imem_pipe: pipelined instruction memory with in-order responses.
// Ports: req_* (fetch handshake), rsp_* (response handshake), flush_i,
// load_* (program write port), clk_i, rst_i (sync, active-high).
module imem_pipe
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [XLEN-1:0]          req_addr_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [XLEN-1:0]          rsp_instr_o,
    output logic [XLEN-1:0]          rsp_addr_o,
    output logic                     rsp_err_o,
    input  logic                     flush_i,
    input  logic                     load_we_i,
    input  logic [$clog2(DEPTH)-1:0] load_addr_i,
    input  logic [XLEN-1:0]          load_data_i
);

    localparam int unsigned IW     = $clog2(DEPTH);
    localparam int unsigned QDEPTH = LATENCY + 1;
    localparam int unsigned CW     = $clog2(QDEPTH + 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(IMEM_NOP);

    typedef struct packed {
        logic            vld;
        logic            err;
        logic [IW-1:0]   idx;
        logic [XLEN-1:0] addr;
    } stg_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
        logic            err;
    } rsp_t;

    stg_t            in_s;
    stg_t            rd_s;
    rsp_t            push_data;
    rsp_t            head;
    logic            accept;
    logic            rsp_hs;
    logic            fifo_empty;
    logic            unused_full;
    logic [CW-1:0]   count_q, count_d;

    // Program store; power-up image is all NOPs, reset leaves it alone.
    logic [XLEN-1:0] mem_q [DEPTH] = '{default: NOP};

    // The outstanding count bounds the queue, so it can never overflow.
    assign req_ready_o = !rst_i && !flush_i && (count_q < CW'(QDEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = !rst_i && !fifo_empty;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;

    assign rsp_instr_o = rsp_valid_o ? head.instr : '0;
    assign rsp_addr_o  = rsp_valid_o ? head.addr : '0;
    assign rsp_err_o   = rsp_valid_o && head.err;

    // Illegal PCs are steered to word 0 so the array index stays legal.
    always_comb begin
        in_s.vld  = accept;
        in_s.err  = imem_pc_err(64'(req_addr_i), DEPTH);
        in_s.idx  = in_s.err ? '0 : req_addr_i[IW+1:2];
        in_s.addr = req_addr_i;
    end

    generate
        if (LATENCY == 1) begin : g_nodly
            assign rd_s = in_s;
        end else begin : g_dly
            stg_t dly_q [LATENCY-1];

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= in_s;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign rd_s = dly_q[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    // The queue captures the word at the same edge a load may update it,
    // so a colliding fetch sees the pre-write contents.
    always_comb begin
        push_data.addr  = rd_s.addr;
        push_data.err   = rd_s.err;
        push_data.instr = rd_s.err ? NOP : mem_q[rd_s.idx];
    end

    imem_rsp_fifo #(
        .DEPTH (QDEPTH),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (rd_s.vld),
        .data_i  (push_data),
        .pop_i   (rsp_hs),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (unused_full)
    );

    always_comb begin
        count_d = count_q;
        if (accept && !rsp_hs) begin
            count_d = count_q + CW'(1);
        end else if (!accept && rsp_hs) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe: scenario tasks plus randomized traffic checked against
// a queue-based model of the instruction memory.
module tb_imem_pipe;

    localparam int DEPTH = 256;
    localparam int IW    = $clog2(DEPTH);
    localparam int LAT   = 2;
    localparam int QD    = LAT + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h00A0_2093;
    localparam logic [31:0] W1  = 32'h0140_2113;
    localparam logic [31:0] W2  = 32'h0020_81B3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [31:0]   req_addr_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_instr_o;
    logic [31:0]   rsp_addr_o;
    logic          rsp_err_o;
    logic          flush_i;
    logic          load_we_i;
    logic [IW-1:0] load_addr_i;
    logic [31:0]   load_data_i;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } ent_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } ev_t;

    ent_t        q[$];
    ev_t         obs[$];
    ev_t         expq[$];
    logic [31:0] mm [DEPTH];
    int          cyc;
    int          tests;
    int          fails;
    int          n_acc_dut;
    int          n_acc_m;

    always #5 clk = ~clk;

    imem_pipe #(
        .DEPTH   (DEPTH),
        .XLEN    (32),
        .LATENCY (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_instr_o (rsp_instr_o),
        .rsp_addr_o  (rsp_addr_o),
        .rsp_err_o   (rsp_err_o),
        .flush_i     (flush_i),
        .load_we_i   (load_we_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i)
    );

    // Model: q holds every accepted, unconsumed fetch with the cycle in
    // which it becomes visible (accept cycle + LAT).
    function automatic logic exp_ready();
        return !rst_i && !flush_i && (q.size() < QD);
    endfunction

    function automatic logic exp_valid();
        return !rst_i && (q.size() > 0) && (q[0].due <= cyc);
    endfunction

    task automatic idle();
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        load_we_i   = 1'b0;
    endtask

    task automatic clear_log();
        obs.delete();
        expq.delete();
    endtask

    // One clock: record DUT handshakes, advance the model, step the edge.
    task automatic tick();
        logic acc_m;
        logic hs_m;
        ent_t e;
        ev_t  ev;
        #1;
        acc_m = req_valid_i && exp_ready();
        hs_m  = rsp_ready_i && exp_valid();
        if (req_valid_i && req_ready_o) n_acc_dut++;
        if (rsp_valid_o && rsp_ready_i) begin
            ev.cyc = 32'(cyc);
            ev.addr = rsp_addr_o;
            ev.instr = rsp_instr_o;
            ev.err = rsp_err_o;
            obs.push_back(ev);
        end
        if (hs_m) begin
            ev.cyc = 32'(cyc);
            ev.addr = q[0].addr;
            ev.instr = q[0].instr;
            ev.err = q[0].err;
            expq.push_back(ev);
        end
        if (rst_i || flush_i) begin
            q.delete();
        end else begin
            if (hs_m) void'(q.pop_front());
            if (acc_m) begin
                n_acc_m++;
                e.due = cyc + LAT;
                e.addr = req_addr_i;
                e.err = (req_addr_i[1:0] != 2'b00) ||
                        (req_addr_i >= 32'(DEPTH * 4));
                e.instr = NOP;
                q.push_back(e);
            end
        end
        // The array is read one cycle before the response shows up,
        // ahead of any load landing on the same edge.
        foreach (q[i]) begin
            if (q[i].due == cyc + 1 && !q[i].err)
                q[i].instr = mm[int'(q[i].addr >> 2)];
        end
        if (load_we_i) mm[load_addr_i] = load_data_i;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        rsp_ready_i = 1'b0;
        req_addr_i = '0;
        load_addr_i = '0;
        load_data_i = '0;
        #1;
        tests++;
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: ready=%b valid=%b want 0 0",
                     req_ready_o, rsp_valid_o);
        end
        tests++;
        if (rsp_instr_o !== 32'h0 || rsp_addr_o !== 32'h0 ||
            rsp_err_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: instr=%h addr=%h err=%b want 0",
                     rsp_instr_o, rsp_addr_o, rsp_err_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        tests++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: ready=%b valid=%b want 1 0",
                     req_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] w [3];
        int          a;
        w = '{W0, W1, W2};
        idle();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_we_i = 1'b1;
            load_addr_i = IW'(i);
            load_data_i = w[i];
            tick();
        end
        load_we_i = 1'b0;
        clear_log();
        a = cyc;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_addr_i = 32'(4 * i);
            tick();
        end
        req_valid_i = 1'b0;
        repeat (LAT + 3) tick();
        tests++;
        if (obs.size() != 3) begin
            fails++;
            $display("FAIL basic_count: got %0d want 3", obs.size());
        end
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            tests++;
            if (obs[i].instr !== w[i] || obs[i].addr !== 32'(4 * i) ||
                obs[i].err !== 1'b0 || obs[i].cyc !== 32'(a + LAT + i)) begin
                fails++;
                $display("FAIL basic_rsp%0d: got c=%0d a=%h i=%h e=%b want c=%0d a=%h i=%h e=0",
                         i, obs[i].cyc, obs[i].addr, obs[i].instr, obs[i].err,
                         a + LAT + i, 4 * i, w[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int m0;
        idle();
        rsp_ready_i = 1'b0;
        clear_log();
        n_acc_dut = 0;
        m0 = n_acc_m;
        for (int i = 0; i < QD + 3; i++) begin
            req_valid_i = 1'b1;
            req_addr_i = 32'(4 * (n_acc_m - m0));
            tick();
        end
        req_valid_i = 1'b0;
        #1;
        tests++;
        if (n_acc_dut != QD || req_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: got %0d ready=%b want %0d ready=0",
                     n_acc_dut, req_ready_o, QD);
        end
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_addr_o !== 32'h0 ||
            rsp_instr_o !== W0) begin
            fails++;
            $display("FAIL bp_hold: v=%b a=%h i=%h want v=1 a=0 i=%h",
                     rsp_valid_o, rsp_addr_o, rsp_instr_o, W0);
        end
        rsp_ready_i = 1'b1;
        repeat (QD + 2) tick();
        #1;
        tests++;
        if (obs.size() != QD || req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_drain: got %0d ready=%b want %0d ready=1",
                     obs.size(), req_ready_o, QD);
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            tests++;
            if (obs[i] !== expq[i]) begin
                fails++;
                $display("FAIL bp_rsp%0d: got c=%0d a=%h i=%h e=%b want c=%0d a=%h i=%h e=%b",
                         i, obs[i].cyc, obs[i].addr, obs[i].instr, obs[i].err,
                         expq[i].cyc, expq[i].addr, expq[i].instr, expq[i].err);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] ad [3];
        logic [31:0] in [3];
        logic        er [3];
        ad = '{32'h6, 32'h400, 32'h0};
        in = '{NOP, NOP, W0};
        er = '{1'b1, 1'b1, 1'b0};
        idle();
        rsp_ready_i = 1'b1;
        clear_log();
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_addr_i = ad[i];
            tick();
        end
        req_valid_i = 1'b0;
        repeat (LAT + 3) tick();
        tests++;
        if (obs.size() != 3) begin
            fails++;
            $display("FAIL err_count: got %0d want 3", obs.size());
        end
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            tests++;
            if (obs[i].addr !== ad[i] || obs[i].instr !== in[i] ||
                obs[i].err !== er[i]) begin
                fails++;
                $display("FAIL err_rsp%0d: got a=%h i=%h e=%b want a=%h i=%h e=%b",
                         i, obs[i].addr, obs[i].instr, obs[i].err,
                         ad[i], in[i], er[i]);
            end
        end
    endtask

    task automatic test_flush();
        idle();
        rsp_ready_i = 1'b0;
        clear_log();
        req_valid_i = 1'b1;
        req_addr_i = 32'h0;
        tick();
        req_addr_i = 32'h4;
        tick();
        req_addr_i = 32'h8;
        flush_i = 1'b1;
        #1;
        tests++;
        if (req_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready: got %b want 0", req_ready_o);
        end
        tick();
        idle();
        #1;
        tests++;
        if (rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_valid: got %b want 0", rsp_valid_o);
        end
        rsp_ready_i = 1'b1;
        tick();
        req_valid_i = 1'b1;
        req_addr_i = 32'h4;
        tick();
        req_valid_i = 1'b0;
        repeat (LAT + 3) tick();
        tests++;
        if (obs.size() != 1) begin
            fails++;
            $display("FAIL flush_count: got %0d want 1", obs.size());
        end else begin
            tests++;
            if (obs[0].addr !== 32'h4 || obs[0].instr !== W1 ||
                obs[0].err !== 1'b0) begin
                fails++;
                $display("FAIL flush_rsp: got a=%h i=%h e=%b want a=4 i=%h e=0",
                         obs[0].addr, obs[0].instr, obs[0].err, W1);
            end
        end
    endtask

    task automatic test_load_collision();
        idle();
        rsp_ready_i = 1'b1;
        load_we_i = 1'b1;
        load_addr_i = IW'(1);
        load_data_i = 32'h1111_1111;
        tick();
        load_we_i = 1'b0;
        clear_log();
        req_addr_i = 32'h4;
        for (int k = 0; k < LAT; k++) begin
            req_valid_i = (k == 0);
            load_we_i = (k == LAT - 1);
            load_data_i = 32'h2222_2222;
            tick();
        end
        idle();
        repeat (LAT + 2) tick();
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        repeat (LAT + 2) tick();
        tests++;
        if (obs.size() != 2) begin
            fails++;
            $display("FAIL coll_count: got %0d want 2", obs.size());
        end else begin
            tests++;
            if (obs[0].instr !== 32'h1111_1111 ||
                obs[1].instr !== 32'h2222_2222) begin
                fails++;
                $display("FAIL coll_data: got %h %h want 11111111 22222222",
                         obs[0].instr, obs[1].instr);
            end
        end
    endtask

    task automatic test_reset_midstream();
        idle();
        rsp_ready_i = 1'b0;
        clear_log();
        req_valid_i = 1'b1;
        req_addr_i = 32'h0;
        tick();
        req_addr_i = 32'h4;
        tick();
        req_valid_i = 1'b0;
        repeat (LAT) tick();
        rst_i = 1'b1;
        #1;
        tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 ||
            rsp_instr_o !== 32'h0 || rsp_addr_o !== 32'h0 ||
            rsp_err_o !== 1'b0) begin
            fails++;
            $display("FAIL midrst_out: v=%b r=%b i=%h a=%h e=%b want all 0",
                     rsp_valid_o, req_ready_o, rsp_instr_o, rsp_addr_o,
                     rsp_err_o);
        end
        tick();
        rst_i = 1'b0;
        #1;
        tests++;
        if (rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL midrst_valid: got %b want 0", rsp_valid_o);
        end
        n_acc_dut = 0;
        req_valid_i = 1'b1;
        req_addr_i = 32'h0;
        repeat (QD + 2) tick();
        req_valid_i = 1'b0;
        tests++;
        if (n_acc_dut != QD) begin
            fails++;
            $display("FAIL midrst_count: got %0d accepts want %0d",
                     n_acc_dut, QD);
        end
        rsp_ready_i = 1'b1;
        repeat (QD + 2) tick();
        tests++;
        if (obs.size() != QD) begin
            fails++;
            $display("FAIL midrst_rsp_count: got %0d want %0d",
                     obs.size(), QD);
        end
        for (int i = 0; i < obs.size(); i++) begin
            tests++;
            if (obs[i].instr !== W0 || obs[i].addr !== 32'h0 ||
                obs[i].err !== 1'b0) begin
                fails++;
                $display("FAIL midrst_rsp%0d: got a=%h i=%h e=%b want a=0 i=%h e=0",
                         i, obs[i].addr, obs[i].instr, obs[i].err, W0);
            end
        end
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] a;
        idle();
        clear_log();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            if (r < 9) a = 32'($urandom_range(0, 7) * 4);
            else a = 32'($urandom_range(0, DEPTH * 4 + 31));
            if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_addr_i = a;
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 24) == 0);
            rst_i = ($urandom_range(0, 99) == 0);
            load_we_i = ($urandom_range(0, 4) == 0);
            load_addr_i = IW'($urandom_range(0, 7));
            load_data_i = $urandom;
            tick();
        end
        idle();
        rsp_ready_i = 1'b1;
        repeat (QD + LAT + 2) tick();
        tests++;
        if (obs.size() != expq.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d want %0d",
                     obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            tests++;
            if (obs[i] !== expq[i]) begin
                fails++;
                $display("FAIL rand_rsp%0d: got c=%0d a=%h i=%h e=%b want c=%0d a=%h i=%h e=%b",
                         i, obs[i].cyc, obs[i].addr, obs[i].instr, obs[i].err,
                         expq[i].cyc, expq[i].addr, expq[i].instr, expq[i].err);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        n_acc_dut = 0;
        n_acc_m = 0;
        foreach (mm[i]) mm[i] = NOP;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_errors();
        test_flush();
        test_load_collision();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
